// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back, and drives every datapath select and enable.
module mips_multicycle_ctrl #(
    parameter int OPCODE_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] Opcode,
    // MemRead/MemWrite hold a request until the memory answers with
    // MemReady=1; the access completes in that same cycle and the FSM leaves
    // the memory state on the following edge. MemReady is ignored elsewhere.
    input  logic                MemReady,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic [1:0]          PCSource,
    output logic [1:0]          ALUOp,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic                RegWrite,
    output logic                RegDst,
    output logic                ExtOp,
    output logic [1:0]          ImmOp,
    output logic                InstrDone,
    output logic                Illegal
);

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC,
        RTYPEWB,
        BRANCH,
        IEXEC,
        IWB,
        JUMP,
        ILLEGAL
    } state_t;

    state_t              state;
    state_t              nextState;
    logic [OPCODE_W-1:0] opReg;

    function automatic state_t decodeTarget(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_RTYPE:               return EXEC;
            OP_LW, OP_SW:           return MEMADR;
            OP_BEQ:                 return BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI: return IEXEC;
            OP_J:                   return JUMP;
            default:                return ILLEGAL;
        endcase
    endfunction

    // The opcode is captured in DECODE so later states ignore IR changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            opReg <= '0;
        end else begin
            state <= nextState;
            if (state == DECODE) begin
                opReg <= Opcode;
            end
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = FETCH;
            FETCH:   nextState = MemReady ? DECODE : FETCH;
            DECODE:  nextState = decodeTarget(Opcode);
            MEMADR:  nextState = (opReg == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   nextState = MemReady ? MEMWB : MEMRD;
            MEMWB:   nextState = FETCH;
            MEMWR:   nextState = MemReady ? FETCH : MEMWR;
            EXEC:    nextState = RTYPEWB;
            RTYPEWB: nextState = FETCH;
            BRANCH:  nextState = FETCH;
            IEXEC:   nextState = IWB;
            IWB:     nextState = FETCH;
            JUMP:    nextState = FETCH;
            ILLEGAL: nextState = ILLEGAL;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ExtOp       = 1'b0;
        ImmOp       = 2'b00;
        InstrDone   = 1'b0;
        Illegal     = 1'b0;
        case (state)
            FETCH: begin
                // PC+4 is computed every cycle but only committed with the IR.
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b00;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                ExtOp   = 1'b1;
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ExtOp   = 1'b1;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                InstrDone = 1'b1;
            end
            MEMWR: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                InstrDone = MemReady;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            RTYPEWB: begin
                RegDst    = 1'b1;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                InstrDone   = 1'b1;
            end
            IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
                // Logical immediates are zero-extended; addi is sign-extended.
                case (opReg)
                    OP_ADDI: begin
                        ExtOp = 1'b1;
                        ImmOp = 2'b00;
                    end
                    OP_ANDI: begin
                        ExtOp = 1'b0;
                        ImmOp = 2'b01;
                    end
                    OP_ORI: begin
                        ExtOp = 1'b0;
                        ImmOp = 2'b10;
                    end
                    default: begin
                        ExtOp = 1'b0;
                        ImmOp = 2'b00;
                    end
                endcase
            end
            IWB: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b0;
                MemtoReg  = 1'b0;
                InstrDone = 1'b1;
            end
            JUMP: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b10;
                InstrDone = 1'b1;
            end
            ILLEGAL: begin
                Illegal = 1'b1;
            end
            default: begin
                PCWrite = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: a per-instruction reference model
// pushes the expected control word for every cycle; a monitor pops and compares.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic [1:0] pcSource;
        logic [1:0] aluOp;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic       regWrite;
        logic       regDst;
        logic       extOp;
        logic [1:0] immOp;
        logic       instrDone;
        logic       illegal;
    } ctrl_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
    logic [1:0] PCSource, ALUOp, ALUSrcB, ImmOp;
    logic       ALUSrcA, RegWrite, RegDst, ExtOp, InstrDone, Illegal;

    ctrl_t      act;
    ctrl_t      exp_q[$];
    string      lbl_q[$];
    int         checks = 0;
    int         errors = 0;

    logic [5:0] legalOps[8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h02};

    mips_multicycle_ctrl #(.OPCODE_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .RegDst(RegDst), .ExtOp(ExtOp), .ImmOp(ImmOp),
        .InstrDone(InstrDone), .Illegal(Illegal)
    );

    assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, ExtOp,
                  ImmOp, InstrDone, Illegal};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    function automatic void check(input string name, input logic [20:0] got,
                                  input logic [20:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endfunction

    // monitor: the DUT presents a control word every cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ctrl_t e;
            string l;
            e = exp_q.pop_front();
            l = lbl_q.pop_front();
            check(l, act, e);
        end
    end

    // driver: apply inputs for one cycle and record what that cycle must show
    task automatic drive(input logic mr, input logic [5:0] op, input ctrl_t e,
                         input string lbl);
        MemReady = mr;
        Opcode   = op;
        exp_q.push_back(e);
        lbl_q.push_back(lbl);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] junk();
        return 6'($urandom);
    endfunction

    // called at the start of an unrecorded cycle
    task automatic resetNow();
        ctrl_t z;
        z = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", act, z);
        MemReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", act, z);
        rst_n = 1'b1;
        drive(rbit(), junk(), z, "idle");
    endtask

    // reference model: expected control words for one instruction
    task automatic runInstr(input logic [5:0] op, input int fStall, input int mStall,
                            input int abortAt);
        ctrl_t e;
        logic  mr;
        for (int i = 0; i <= fStall; i++) begin
            mr = (i == fStall);
            e = '0; e.memRead = 1'b1; e.aluSrcB = 2'b01;
            e.irWrite = mr; e.pcWrite = mr;
            drive(mr, junk(), e, "fetch");
        end
        e = '0; e.aluSrcB = 2'b11; e.extOp = 1'b1;
        drive(rbit(), op, e, "decode");
        case (op)
            6'h00: begin
                e = '0; e.aluSrcA = 1'b1; e.aluOp = 2'b10;
                drive(rbit(), junk(), e, "exec");
                e = '0; e.regDst = 1'b1; e.regWrite = 1'b1; e.instrDone = 1'b1;
                drive(rbit(), junk(), e, "rtype_wb");
            end
            6'h23, 6'h2B: begin
                e = '0; e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; e.extOp = 1'b1;
                drive(rbit(), junk(), e, "mem_adr");
                for (int i = 0; i <= mStall; i++) begin
                    if (i == abortAt) return;
                    mr = (i == mStall);
                    e = '0; e.iorD = 1'b1;
                    if (op == 6'h23) begin
                        e.memRead = 1'b1;
                        drive(mr, junk(), e, "mem_read");
                    end else begin
                        e.memWrite = 1'b1; e.instrDone = mr;
                        drive(mr, junk(), e, "mem_write");
                    end
                end
                if (op == 6'h23) begin
                    e = '0; e.regWrite = 1'b1; e.memtoReg = 1'b1; e.instrDone = 1'b1;
                    drive(rbit(), junk(), e, "mem_wb");
                end
            end
            6'h04: begin
                e = '0; e.aluSrcA = 1'b1; e.aluOp = 2'b01; e.pcWriteCond = 1'b1;
                e.pcSource = 2'b01; e.instrDone = 1'b1;
                drive(rbit(), junk(), e, "branch");
            end
            6'h08, 6'h0C, 6'h0D: begin
                e = '0; e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; e.aluOp = 2'b11;
                e.extOp = (op == 6'h08);
                e.immOp = (op == 6'h0C) ? 2'b01 : ((op == 6'h0D) ? 2'b10 : 2'b00);
                drive(rbit(), junk(), e, "imm_exec");
                e = '0; e.regWrite = 1'b1; e.instrDone = 1'b1;
                drive(rbit(), junk(), e, "imm_wb");
            end
            6'h02: begin
                e = '0; e.pcWrite = 1'b1; e.pcSource = 2'b10; e.instrDone = 1'b1;
                drive(rbit(), junk(), e, "jump");
            end
            default: begin
                for (int i = 0; i < 20; i++) begin
                    e = '0; e.illegal = 1'b1;
                    drive(rbit(), junk(), e, "illegal_hold");
                end
            end
        endcase
    endtask

    initial begin
        ctrl_t e;
        rst_n    = 1'b0;
        MemReady = 1'b0;
        Opcode   = 6'h00;
        #2;
        check("reset_state", act, ctrl_t'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 6'h00, ctrl_t'(0), "idle");

        // reset while FETCH waits on memory
        e = '0; e.memRead = 1'b1; e.aluSrcB = 2'b01;
        drive(1'b0, junk(), e, "fetch_wait");
        resetNow();

        runInstr(6'h23, 0, 0, -1);
        runInstr(6'h2B, 0, 3, -1);
        runInstr(6'h0C, 0, 0, -1);
        runInstr(6'h08, 0, 0, -1);
        runInstr(6'h0D, 0, 0, -1);
        runInstr(6'h00, 5, 0, -1);
        runInstr(6'h04, 0, 0, -1);
        runInstr(6'h02, 0, 0, -1);

        // abort a stalled store and a stalled load with reset
        runInstr(6'h2B, 0, 4, 2);
        resetNow();
        runInstr(6'h23, 1, 3, 1);
        resetNow();

        for (int n = 0; n < 150; n++) begin
            runInstr(legalOps[$urandom_range(0, 7)], $urandom_range(0, 2),
                     $urandom_range(0, 2), -1);
        end

        runInstr(6'h3F, 0, 0, -1);
        resetNow();
        runInstr(6'h23, 0, 0, -1);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
